// File: rtl/lbm_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lbm_frame_scheduler
// Description : Hands the shared BRAM port back and forth between the LBM
//               solver and the stream readout, one iteration at a time.
//               Optional decimation is enabled with the macro FRAME_DECIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lbm_frame_scheduler #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int ITER_WIDTH    = 16,
  parameter int DECIM         = 4
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_aresetn,
  input  logic                     run,
  input  logic [ITER_WIDTH-1:0]    num_iters,
  input  logic                     stop,
  output logic                     solver_start,
  input  logic                     solver_done,
  input  logic [ADDRESS_WIDTH-1:0] solver_addr,
  input  logic                     solver_we,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [ADDRESS_WIDTH-1:0] bram_addr,
  output logic                     bram_we,
  output logic                     chunk_transfer_ready,
  output logic                     frame_ready,
  input  logic                     s_tvalid,
  input  logic                     s_tready,
  input  logic                     s_tlast,
  output logic                     busy,
  output logic [ITER_WIDTH-1:0]    iter_count,
  output logic [15:0]              frames_sent,
  output logic                     err
);

`ifdef FRAME_DECIM_EN
  localparam logic c_decim_en = 1'b1;
`else
  localparam logic c_decim_en = 1'b0;
`endif
  localparam logic [ITER_WIDTH-1:0] c_decim = ITER_WIDTH'(DECIM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SOLVE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ITER_WIDTH-1:0]   r_limit;
  logic                    r_stop_pend;

  logic                    w_run_ok;
  logic                    w_done_ok;
  logic                    w_tlast_beat;
  logic                    w_last_ok;
  logic                    w_stop_eff;
  logic                    w_stream;
  logic                    w_err_evt;
  logic [ITER_WIDTH-1:0]   w_iter_inc;

  assign w_run_ok     = run && (num_iters != '0) && (r_state == S_IDLE);
  assign w_done_ok    = solver_done && (r_state == S_SOLVE);
  assign w_tlast_beat = s_tvalid && s_tready && s_tlast;
  assign w_last_ok    = w_tlast_beat && (r_state == S_DRAIN);
  assign w_iter_inc   = iter_count + ITER_WIDTH'(1);
  // A stop arriving together with the boundary event still counts for that boundary.
  assign w_stop_eff   = r_stop_pend || stop;

  assign w_stream = !c_decim_en
                 || ((w_iter_inc % c_decim) == '0)
                 || (w_iter_inc == r_limit)
                 || w_stop_eff;

  assign w_err_evt = (solver_done && (r_state != S_SOLVE))
                  || (solver_we && !chunk_transfer_ready)
                  || (w_tlast_beat && (r_state != S_DRAIN));

  assign bram_addr = chunk_transfer_ready ? solver_addr : rd_addr;
  assign bram_we   = solver_we && chunk_transfer_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_run_ok) w_state_next = S_START;
      S_START: w_state_next = S_SOLVE;
      S_SOLVE: begin
        if (w_done_ok) begin
          if (w_stream)
            w_state_next = S_DRAIN;
          else if ((w_iter_inc < r_limit) && !w_stop_eff)
            w_state_next = S_START;
          else
            w_state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_last_ok) begin
          if ((iter_count < r_limit) && !w_stop_eff)
            w_state_next = S_START;
          else
            w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state              <= S_IDLE;
      r_limit              <= '0;
      r_stop_pend          <= 1'b0;
      iter_count           <= '0;
      frames_sent          <= '0;
      err                  <= 1'b0;
      solver_start         <= 1'b0;
      chunk_transfer_ready <= 1'b0;
      frame_ready          <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      r_state              <= w_state_next;
      solver_start         <= (w_state_next == S_START);
      chunk_transfer_ready <= (w_state_next == S_START) || (w_state_next == S_SOLVE);
      frame_ready          <= (w_state_next == S_DRAIN);
      busy                 <= (w_state_next != S_IDLE);

      if (r_state == S_IDLE)
        r_stop_pend <= 1'b0;
      else if (stop)
        r_stop_pend <= 1'b1;

      if (w_run_ok) begin
        r_limit    <= num_iters;
        iter_count <= '0;
      end else if (w_done_ok) begin
        iter_count <= w_iter_inc;
      end

      if (w_last_ok)
        frames_sent <= frames_sent + 16'd1;

      err <= (err && !w_run_ok) || w_err_evt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbm_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbm_frame_scheduler
// Description : Randomised sessions against an iteration/frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbm_frame_scheduler;
  localparam int AW    = 12;
  localparam int IW    = 16;
  localparam int DECIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [IW-1:0] num_iters = '0;
  logic          stop = 1'b0;
  logic          solver_start;
  logic          solver_done = 1'b0;
  logic [AW-1:0] solver_addr = '0;
  logic          solver_we = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic          chunk_transfer_ready;
  logic          frame_ready;
  logic          s_tvalid = 1'b0;
  logic          s_tready = 1'b0;
  logic          s_tlast = 1'b0;
  logic          busy;
  logic [IW-1:0] iter_count;
  logic [15:0]   frames_sent;
  logic          err;

  lbm_frame_scheduler #(.ADDRESS_WIDTH(AW), .ITER_WIDTH(IW), .DECIM(DECIM)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .run(run), .num_iters(num_iters),
    .stop(stop), .solver_start(solver_start), .solver_done(solver_done),
    .solver_addr(solver_addr), .solver_we(solver_we), .rd_addr(rd_addr),
    .bram_addr(bram_addr), .bram_we(bram_we), .chunk_transfer_ready(chunk_transfer_ready),
    .frame_ready(frame_ready), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .busy(busy), .iter_count(iter_count), .frames_sent(frames_sent), .err(err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_frames_sent = '0;
  int          obs_starts;
  int          obs_frames;
  bit          obs_timeout;
  bit          obs_fr [1:40];
  bit          obs_ss [1:40];

  localparam int SM_NONE = 0, SM_DONE = 1, SM_SOLVE = 2, SM_DRAIN = 3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the run ends at the stop iteration (if any) or the limit.
  function automatic int last_iter(input int n, input int stop_iter);
    return (stop_iter > 0 && stop_iter < n) ? stop_iter : n;
  endfunction

  function automatic int streamed(input int i, input int last);
`ifdef FRAME_DECIM_EN
    return ((i % DECIM) == 0 || i == last) ? 1 : 0;
`else
    return (i >= 1 && i <= last) ? 1 : 0;
`endif
  endfunction

  // Solver and readout emulator for one run; records what it sees.
  task automatic drive_session(input int n, input int lat, input int beats,
                               input int stop_iter, input int stop_mode);
    int it;
    int b;
    int guard;
    bit got;
    it = 0;
    obs_starts = 0;
    obs_frames = 0;
    obs_timeout = 0;
    for (int k = 1; k <= 40; k++) begin
      obs_fr[k] = 0;
      obs_ss[k] = 0;
    end
    num_iters = IW'(n);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int loop = 0; loop < 40; loop++) begin
      got = 0;
      for (int c = 0; c < 10; c++) begin
        if (solver_start) begin
          got = 1;
          break;
        end
        tick();
      end
      if (!got) begin
        obs_timeout = 1;
        break;
      end
      it++;
      obs_starts++;
      tick();
      run = 1'b1;
      num_iters = IW'(n + 7);
      if (it == stop_iter && stop_mode == SM_SOLVE) stop = 1'b1;
      for (int k = 1; k < lat; k++) begin
        tick();
        run = 1'b0;
        stop = 1'b0;
      end
      solver_done = 1'b1;
      if (it == stop_iter && stop_mode == SM_DONE) stop = 1'b1;
      tick();
      solver_done = 1'b0;
      stop = 1'b0;
      run = 1'b0;
      num_iters = IW'(n);
      if (it <= 40) obs_fr[it] = frame_ready;
      if (frame_ready) begin
        obs_frames++;
        b = 0;
        guard = 0;
        while (b < beats && guard < beats * 30) begin
          s_tvalid = ($urandom_range(0, 9) != 0);
          s_tready = ($urandom_range(0, 9) < 8);
          s_tlast  = (b == beats - 1);
          stop     = (it == stop_iter && stop_mode == SM_DRAIN && b == beats / 2);
          tick();
          guard++;
          if (s_tvalid && s_tready) b++;
        end
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast = 1'b0;
        stop = 1'b0;
        if (b < beats) obs_timeout = 1;
      end
      if (it <= 40) obs_ss[it] = solver_start;
      if (!busy || obs_timeout) break;
    end
  endtask

  task automatic test_reset();
    rd_addr = AW'($urandom);
    #1;
    n_tests++;
    if ({solver_start, chunk_transfer_ready, frame_ready, busy, bram_we, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {solver_start, chunk_transfer_ready, frame_ready, busy, bram_we, err});
    end
    n_tests++;
    if (iter_count !== '0 || frames_sent !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got iter=%0d frames=%0d want 0 0", iter_count, frames_sent);
    end
    n_tests++;
    if (bram_addr !== rd_addr) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want %h", bram_addr, rd_addr);
    end
  endtask

  task automatic test_zero_iters();
    num_iters = '0;
    run = 1'b1;
    tick();
    run = 1'b0;
    n_tests++;
    if (solver_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_iters: got start=%b busy=%b want 0 0", solver_start, busy);
    end
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || iter_count !== '0) begin
      n_fail++;
      $display("FAIL zero_iters_idle: got busy=%b iter=%0d want 0 0", busy, iter_count);
    end
  endtask

  task automatic test_ownership();
    logic [AW-1:0] sa;
    logic [AW-1:0] ra;
    num_iters = IW'(1);
    run = 1'b1;
    tick();
    run = 1'b0;
    n_tests++;
    if (solver_start !== 1'b1 || chunk_transfer_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_latency: got start=%b ctr=%b want 1 1", solver_start, chunk_transfer_ready);
    end
    sa = AW'($urandom);
    solver_addr = sa;
    solver_we = 1'b1;
    #1;
    n_tests++;
    if (bram_addr !== sa || bram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL solver_owns: got addr=%h we=%b want %h 1", bram_addr, bram_we, sa);
    end
    tick();
    n_tests++;
    if (solver_start !== 1'b0 || frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL solve_state: got start=%b fr=%b want 0 0", solver_start, frame_ready);
    end
    solver_we = 1'b0;
    solver_done = 1'b1;
    tick();
    solver_done = 1'b0;
    n_tests++;
    if (frame_ready !== 1'b1 || chunk_transfer_ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_latency: got fr=%b ctr=%b err=%b want 1 0 0",
               frame_ready, chunk_transfer_ready, err);
    end
    ra = AW'($urandom);
    rd_addr = ra;
    solver_addr = ~ra;
    solver_we = 1'b1;
    #1;
    n_tests++;
    if (bram_addr !== ra || bram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_gate: got addr=%h we=%b want %h 0", bram_addr, bram_we, ra);
    end
    tick();
    solver_we = 1'b0;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL we_err: got %b want 1", err);
    end
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    s_tlast = 1'b0;
    exp_frames_sent = exp_frames_sent + 16'd1;
    n_tests++;
    if (frame_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || frames_sent !== exp_frames_sent) begin
      n_fail++;
      $display("FAIL tlast_end: got fr=%b busy=%b err=%b frames=%0d want 0 0 1 %0d",
               frame_ready, busy, err, frames_sent, exp_frames_sent);
    end
    drive_session(1, 2, 3, 0, SM_NONE);
    exp_frames_sent = exp_frames_sent + 16'd1;
    n_tests++;
    if (err !== 1'b0 || obs_timeout) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b timeout=%b want 0 0", err, obs_timeout);
    end
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    s_tlast = 1'b0;
    n_tests++;
    if (err !== 1'b1 || frames_sent !== exp_frames_sent) begin
      n_fail++;
      $display("FAIL idle_tlast: got err=%b frames=%0d want 1 %0d", err, frames_sent, exp_frames_sent);
    end
    drive_session(1, 1, 1, 0, SM_NONE);
    exp_frames_sent = exp_frames_sent + 16'd1;
    solver_done = 1'b1;
    tick();
    solver_done = 1'b0;
    n_tests++;
    if (err !== 1'b1 || iter_count !== IW'(1) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: got err=%b iter=%0d busy=%b want 1 1 0", err, iter_count, busy);
    end
  endtask

  task automatic test_sessions();
    int n;
    int lat;
    int beats;
    int si;
    int sm;
    int li;
    int nf;
    for (int r = 0; r < 10; r++) begin
      if (r == 0) begin
        n = 3; lat = 20; beats = 2500; si = 0; sm = SM_NONE;
      end else if (r == 1) begin
        n = 5; lat = 4; beats = 40; si = 1;
`ifdef FRAME_DECIM_EN
        sm = SM_DONE;
`else
        sm = SM_DRAIN;
`endif
      end else begin
        n = $urandom_range(1, 6);
        lat = $urandom_range(1, 8);
        beats = $urandom_range(1, 20);
        si = $urandom_range(0, n);
        sm = (si == 0) ? SM_NONE : $urandom_range(SM_DONE, SM_SOLVE);
      end
      drive_session(n, lat, beats, si, sm);
      li = last_iter(n, si);
      nf = 0;
      for (int i = 1; i <= li; i++) nf += streamed(i, li);
      exp_frames_sent = exp_frames_sent + 16'(nf);
      n_tests++;
      if (obs_timeout || obs_starts != li) begin
        n_fail++;
        $display("FAIL sess%0d_starts: got %0d (timeout=%b) want %0d", r, obs_starts, obs_timeout, li);
      end
      n_tests++;
      if (obs_frames != nf || frames_sent !== exp_frames_sent) begin
        n_fail++;
        $display("FAIL sess%0d_frames: got %0d/%0d want %0d/%0d", r, obs_frames, frames_sent, nf, exp_frames_sent);
      end
      n_tests++;
      if (iter_count !== IW'(li) || busy !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL sess%0d_end: got iter=%0d busy=%b err=%b want %0d 0 0", r, iter_count, busy, err, li);
      end
      for (int i = 1; i <= li; i++) begin
        n_tests++;
        if (int'(obs_fr[i]) != streamed(i, li) || obs_ss[i] != (i < li)) begin
          n_fail++;
          $display("FAIL sess%0d_iter%0d: got fr=%b start=%b want %0d %0d",
                   r, i, obs_fr[i], obs_ss[i], streamed(i, li), (i < li));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    num_iters = IW'(2);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    solver_done = 1'b1;
    tick();
    solver_done = 1'b0;
    n_tests++;
    if (frame_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got fr=%b want 1", frame_ready);
    end
    s_tvalid = 1'b1;
    s_tready = 1'b1;
    repeat (1200) tick();
    rst_n = 1'b0;
    rd_addr = AW'($urandom);
    solver_addr = ~rd_addr;
    tick();
    s_tvalid = 1'b0;
    s_tready = 1'b0;
    n_tests++;
    if ({solver_start, chunk_transfer_ready, frame_ready, busy, bram_we, err} !== 6'b0 ||
        iter_count !== '0 || frames_sent !== '0 || bram_addr !== rd_addr) begin
      n_fail++;
      $display("FAIL rst_mid: got flags=%b iter=%0d frames=%0d addr=%h want 000000 0 0 %h",
               {solver_start, chunk_transfer_ready, frame_ready, busy, bram_we, err},
               iter_count, frames_sent, bram_addr, rd_addr);
    end
    rst_n = 1'b1;
    exp_frames_sent = '0;
    tick();
    drive_session(2, 3, 10, 0, SM_NONE);
    exp_frames_sent = 16'(streamed(1, 2) + streamed(2, 2));
    n_tests++;
    if (obs_timeout || obs_starts != 2 || iter_count !== IW'(2) || frames_sent !== exp_frames_sent) begin
      n_fail++;
      $display("FAIL rst_rerun: got starts=%0d iter=%0d frames=%0d want 2 2 %0d",
               obs_starts, iter_count, frames_sent, exp_frames_sent);
    end
  endtask

`ifdef FRAME_DECIM_EN
  task automatic test_decim();
    logic [15:0] before;
    before = frames_sent;
    drive_session(10, 2, 5, 0, SM_NONE);
    n_tests++;
    if (obs_frames != 3 || frames_sent !== before + 16'd3 ||
        !obs_fr[4] || !obs_fr[8] || !obs_fr[10] || obs_fr[1] || obs_fr[5] || obs_fr[9]) begin
      n_fail++;
      $display("FAIL decim: got frames=%0d sent=%0d want 3 %0d", obs_frames, frames_sent, before + 16'd3);
    end
    exp_frames_sent = frames_sent;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_zero_iters();
    test_ownership();
    test_sessions();
    test_reset_mid_frame();
`ifdef FRAME_DECIM_EN
    test_decim();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
